// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to 32-bit instruction-memory word loader with pipeline hold

module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load_start,
    input  logic [ADDR_W:0]   i_load_len,
    input  logic [ADDR_W-1:0] i_load_base,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_load_done,
    output logic              o_load_err
);

    // Loader phases: waiting for a request, collecting bytes, writing a word, signalling completion.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Memory depth expressed in the same width as the length input so the
    // range check can accept len == DEPTH exactly.
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [2:0]        r_byte_cnt;
    logic [31:0]       r_shreg;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic              w_idle;
    logic              w_start;
    logic              w_len_too_big;
    logic              w_len_zero;
    logic              w_start_ok;
    logic              w_accept;
    logic              w_last_byte;
    logic              w_last_word;
    logic [31:0]       w_shreg_next;
    logic [ADDR_W-1:0] w_word_addr;

    // Request qualification: load_start only matters while idle.
    assign w_idle        = (r_state == S_IDLE);
    assign w_start       = w_idle & i_load_start;
    assign w_len_too_big = (i_load_len > DEPTH);
    assign w_len_zero    = (i_load_len == '0);
    assign w_start_ok    = w_start & ~w_len_too_big & ~w_len_zero;

    // A byte is taken only while collecting; elsewhere the stream must hold it.
    assign w_accept      = i_byte_valid & (r_state == S_RECV);
    assign w_last_byte   = w_accept & (r_byte_cnt == 3'd3);
    assign w_last_word   = ({1'b0, r_word_cnt} == (r_len - LEN_ONE));

    // Big-endian packing: earlier bytes migrate toward the MSB.
    assign w_shreg_next  = {r_shreg[23:0], i_byte_data};

    // Word address wraps naturally by truncation to ADDR_W bits.
    assign w_word_addr   = r_base + r_word_cnt;

    // Next-state selection for the load sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start && !w_len_too_big) begin
                    w_next_state = w_len_zero ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (w_last_byte) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next_state = w_last_word ? S_DONE : S_RECV;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register; reset returns to idle immediately, abandoning any load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture length and base of an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len  <= '0;
            r_base <= '0;
        end else if (w_start_ok) begin
            r_len  <= i_load_len;
            r_base <= i_load_base;
        end
    end

    // Word counter: cleared on a new load, advanced after each non-final write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
        end else if (w_start_ok) begin
            r_word_cnt <= '0;
        end else if (r_state == S_WRITE && !w_last_word) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    // Byte counter within the current word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
        end else if (w_start_ok || r_state == S_WRITE) begin
            r_byte_cnt <= '0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 3'd1;
        end
    end

    // Shift register assembling the current word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
        end else if (w_accept) begin
            r_shreg <= w_shreg_next;
        end
    end

    // Write address/data are loaded only on entry to WRITE so they stay stable otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_last_byte) begin
            r_addr  <= w_word_addr;
            r_wdata <= w_shreg_next;
        end
    end

    // One-cycle rejection pulse for an oversize request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_start & w_len_too_big;
        end
    end

    assign o_byte_ready = (r_state == S_RECV);
    assign o_imem_we    = (r_state == S_WRITE);
    assign o_cpu_hold   = (r_state != S_IDLE);
    assign o_load_done  = (r_state == S_DONE);
    assign o_load_err   = r_err;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader

module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_start = 1'b0;
    logic [ADDR_W:0]   load_len = '0;
    logic [ADDR_W-1:0] load_base = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_start (load_start),
        .i_load_len   (load_len),
        .i_load_base  (load_base),
        .i_byte_valid (byte_valid),
        .i_byte_data  (byte_data),
        .o_byte_ready (byte_ready),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_wdata (imem_wdata),
        .o_cpu_hold   (cpu_hold),
        .o_load_done  (load_done),
        .o_load_err   (load_err)
    );

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: sole writer of the observation state.
    logic [ADDR_W-1:0] obs_addr_q[$];
    logic [31:0]       obs_data_q[$];
    int                obs_cyc_q[$];
    logic [31:0]       obs_mem[DEPTH];
    int                done_cnt  = 0;
    int                done_cyc  = 0;
    int                err_cnt   = 0;
    int                hold_viol = 0;
    bit                hold_expect = 1'b0;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            obs_addr_q.push_back(imem_addr);
            obs_data_q.push_back(imem_wdata);
            obs_cyc_q.push_back(cycle_cnt);
            obs_mem[imem_addr] = imem_wdata;
        end
        if (load_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cycle_cnt;
        end
        if (load_err === 1'b1) err_cnt = err_cnt + 1;
        if (hold_expect && cpu_hold !== 1'b1) hold_viol = hold_viol + 1;
    end

    // Reference memory image built from the load requests themselves.
    logic [31:0] exp_mem[DEPTH];
    bit          touched[DEPTH];
    logic [7:0]  tx_q[$];
    int          last_acc_cyc = 0;

    // Present tx_q[0..n-1] with random idle gaps; a presented byte is held until taken.
    task automatic drive_bytes(input int n, input int gap_pct, input bit glitch);
        int  idx = 0;
        int  cyc = 0;
        bit  pending = 1'b0;
        bit  gl_done = 1'b0;
        while (idx < n && cyc < 30 * n + 100) begin
            @(negedge clk);
            cyc++;
            if (pending) begin
                byte_valid = 1'b0;
                idx++;
                pending = 1'b0;
            end
            if (glitch && idx == 2 && !gl_done) begin
                load_start = 1'b1;
                load_len   = 9'd5;
                load_base  = 8'h80;
                gl_done    = 1'b1;
            end else begin
                load_start = 1'b0;
            end
            if (idx < n && !byte_valid && $urandom_range(99) >= gap_pct) begin
                byte_valid = 1'b1;
                byte_data  = tx_q[idx];
            end
            if (byte_valid && byte_ready) begin
                pending = 1'b1;
                last_acc_cyc = cycle_cnt;
            end
        end
        byte_valid = 1'b0;
        load_start = 1'b0;
        check("drive_timeout", 64'(idx), 64'(n));
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    endtask

    task automatic run_load(input int len, input int base, input int gap_pct,
                            input bit use_preset, input bit glitch,
                            input bit chk_timing, input bit chk_rate);
        int w0 = obs_addr_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int h0 = hold_viol;
        int ea;
        logic [31:0] ed;
        if (!use_preset) begin
            tx_q.delete();
            for (int i = 0; i < 4 * len; i++) tx_q.push_back(8'($urandom));
        end
        @(negedge clk);
        load_start = 1'b1;
        load_len   = 9'(len);
        load_base  = 8'(base);
        @(negedge clk);
        load_start = 1'b0;
        load_len   = 9'($urandom);
        load_base  = 8'($urandom);
        hold_expect = 1'b1;
        drive_bytes(4 * len, gap_pct, glitch);
        wait_done(d0, 40);
        hold_expect = 1'b0;
        @(negedge clk);
        check("hold_released", 64'(cpu_hold), 64'd0);
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("no_err", 64'(err_cnt - e0), 64'd0);
        check("hold_during_load", 64'(hold_viol - h0), 64'd0);
        check("n_writes", 64'(obs_addr_q.size() - w0), 64'(len));
        for (int i = 0; i < len; i++) begin
            ea = (base + i) % DEPTH;
            ed = {tx_q[4*i], tx_q[4*i+1], tx_q[4*i+2], tx_q[4*i+3]};
            exp_mem[ea] = ed;
            touched[ea] = 1'b1;
            if (w0 + i < obs_addr_q.size()) begin
                check("wr_addr", 64'(obs_addr_q[w0+i]), 64'(ea));
                check("wr_data", 64'(obs_data_q[w0+i]), 64'(ed));
            end
        end
        if (chk_timing && obs_addr_q.size() > w0) begin
            check("we_latency", 64'(obs_cyc_q[w0] - last_acc_cyc), 64'd1);
            check("done_latency", 64'(done_cyc - last_acc_cyc), 64'd2);
        end
        if (chk_rate && obs_addr_q.size() == w0 + len) begin
            check("throughput", 64'(obs_cyc_q[w0+len-1] - obs_cyc_q[w0]), 64'(5 * (len - 1)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_we"},    64'(imem_we),    64'd0);
        check({tag, "_addr"},  64'(imem_addr),  64'd0);
        check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        check({tag, "_hold"},  64'(cpu_hold),   64'd0);
        check({tag, "_done"},  64'(load_done),  64'd0);
        check({tag, "_err"},   64'(load_err),   64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        int e0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single word with latency check.
        tx_q.delete();
        tx_q.push_back(8'h8C);
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h04);
        run_load(1, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Three words with gaps, then wrap at the top of memory.
        run_load(3, 8'h10, 40, 1'b0, 1'b0, 1'b0, 1'b0);
        run_load(2, DEPTH - 1, 30, 1'b0, 1'b0, 1'b0, 1'b0);

        // Zero-length load completes without writes.
        w0 = obs_addr_q.size();
        d0 = done_cnt;
        @(negedge clk);
        load_start = 1'b1;
        load_len   = 9'd0;
        load_base  = 8'h33;
        @(negedge clk);
        load_start = 1'b0;
        check("len0_done", 64'(load_done), 64'd1);
        check("len0_hold", 64'(cpu_hold), 64'd1);
        @(negedge clk);
        check("len0_done_end", 64'(load_done), 64'd0);
        check("len0_hold_end", 64'(cpu_hold), 64'd0);
        check("len0_writes", 64'(obs_addr_q.size() - w0), 64'd0);

        // Oversize request is rejected.
        e0 = err_cnt;
        d0 = done_cnt;
        @(negedge clk);
        load_start = 1'b1;
        load_len   = 9'(DEPTH + 1);
        @(negedge clk);
        load_start = 1'b0;
        check("err_pulse", 64'(load_err), 64'd1);
        check("err_hold", 64'(cpu_hold), 64'd0);
        check("err_ready", 64'(byte_ready), 64'd0);
        @(negedge clk);
        check("err_pulse_end", 64'(load_err), 64'd0);
        repeat (3) @(negedge clk);
        check("err_count", 64'(err_cnt - e0), 64'd1);
        check("err_no_done", 64'(done_cnt - d0), 64'd0);
        check("err_writes", 64'(obs_addr_q.size() - w0), 64'd0);

        // Start pulse during RECV is ignored.
        run_load(2, 8'h20, 20, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset part-way through the first word.
        w0 = obs_addr_q.size();
        tx_q.delete();
        for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
        @(negedge clk);
        load_start = 1'b1;
        load_len   = 9'd2;
        load_base  = 8'h40;
        @(negedge clk);
        load_start = 1'b0;
        drive_bytes(2, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_writes", 64'(obs_addr_q.size() - w0), 64'd0);
        run_load(1, 8'h40, 20, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random loads.
        for (int k = 0; k < 4; k++) begin
            run_load($urandom_range(1, 6), $urandom_range(0, DEPTH - 1),
                     $urandom_range(0, 60), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Full-depth load at peak rate from a random base.
        run_load(DEPTH, $urandom_range(0, DEPTH - 1), 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Memory image must match the reference.
        for (int a = 0; a < DEPTH; a++) begin
            if (touched[a]) check("mem_image", 64'(obs_mem[a]), 64'(exp_mem[a]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
